// File: rtl/viterbi_ctrl.sv
// Viterbi decoder sequencer: accepts one frame of soft symbols, drives the
// branch-metric / ACS / survivor-memory pipeline, then runs traceback.
module viterbi_ctrl #(
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_rx_valid,
    output logic             o_rx_ready,
    output logic             o_en_b,
    output logic             o_en_a,
    output logic             o_sm_we,
    output logic [CNT_W-1:0] o_sm_addr,
    output logic             o_en_t,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, TRACE} state_t;

    // FRAME_LEN may equal 2^CNT_W, so the last index is compared instead of the count
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] b_addr;
    logic [2:1]       vld_pipe;
    logic             accept;

    assign accept   = i_rx_valid && o_rx_ready;
    assign o_en_b   = vld_pipe[1];
    assign o_en_a   = vld_pipe[2];
    assign o_sm_we  = vld_pipe[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            b_addr     <= '0;
            vld_pipe   <= '0;
            o_rx_ready <= 1'b0;
            o_sm_addr  <= '0;
            o_en_t     <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else if (i_abort) begin
            state      <= IDLE;
            cnt        <= '0;
            b_addr     <= '0;
            vld_pipe   <= '0;
            o_rx_ready <= 1'b0;
            o_sm_addr  <= '0;
            o_en_t     <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            // symbol pipeline advances every cycle; gaps travel as bubbles
            vld_pipe  <= {vld_pipe[1], accept};
            o_done    <= 1'b0;
            o_sm_addr <= vld_pipe[1] ? b_addr : '0;
            if (accept) begin
                b_addr <= cnt;
                cnt    <= cnt + ONE;
            end
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state      <= RECV;
                        cnt        <= '0;
                        o_rx_ready <= 1'b1;
                        o_busy     <= 1'b1;
                    end
                end
                RECV: begin
                    if (accept && cnt == LAST) begin
                        state      <= DRAIN;
                        cnt        <= '0;
                        o_rx_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + ONE;
                    if (cnt == ONE) begin
                        state     <= TRACE;
                        o_en_t    <= 1'b1;
                        o_sm_addr <= LAST;
                    end
                end
                TRACE: begin
                    // o_sm_addr doubles as the traceback down-counter
                    if (o_sm_addr == '0) begin
                        state     <= IDLE;
                        o_en_t    <= 1'b0;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        o_sm_addr <= '0;
                    end else begin
                        o_sm_addr <= o_sm_addr - ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Bench for viterbi_ctrl: a schedule-based model books every accepted symbol's
// future en_b/en_a/address slots and the frame's traceback window by cycle number.
module tb_viterbi_ctrl;

    localparam int N     = 4;
    localparam int CW    = 2;
    localparam int W     = 7 + CW;
    localparam int DEPTH = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0, i_abort = 1'b0, i_rx_valid = 1'b0;
    logic          o_rx_ready, o_en_b, o_en_a, o_sm_we, o_en_t, o_busy, o_done;
    logic [CW-1:0] o_sm_addr;

    viterbi_ctrl #(.FRAME_LEN(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready), .o_en_b(o_en_b),
        .o_en_a(o_en_a), .o_sm_we(o_sm_we), .o_sm_addr(o_sm_addr),
        .o_en_t(o_en_t), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_end = -1;
    int m_idx = 0;
    bit m_recv = 0;

    bit exp_ready[DEPTH], exp_en_b[DEPTH], exp_en_a[DEPTH], exp_en_t[DEPTH];
    bit exp_busy[DEPTH], exp_done[DEPTH];
    int exp_addr[DEPTH];

    task automatic clear_from(input int c);
        for (int j = c; j < DEPTH; j++) begin
            exp_ready[j] = 0; exp_en_b[j] = 0; exp_en_a[j] = 0; exp_en_t[j] = 0;
            exp_busy[j] = 0; exp_done[j] = 0; exp_addr[j] = 0;
        end
    endtask

    // Books the consequences of this cycle's inputs into future cycle slots.
    task automatic model(input bit s, input bit a, input bit v);
        int c;
        c = cyc;
        if (a) begin
            clear_from(c + 1);
            m_recv = 0;
            busy_end = c;
        end else if (m_recv) begin
            if (v) begin
                exp_en_b[c+1] = 1;
                exp_en_a[c+2] = 1;
                exp_addr[c+2] = m_idx;
                m_idx++;
                if (m_idx == N) begin
                    m_recv = 0;
                    for (int i = 0; i < N; i++) begin
                        exp_en_t[c+3+i] = 1;
                        exp_addr[c+3+i] = N - 1 - i;
                    end
                    exp_done[c+3+N] = 1;
                    for (int j = c + 1; j <= c + 2 + N; j++) exp_busy[j] = 1;
                    busy_end = c + 2 + N;
                end
            end
            if (m_recv) begin
                exp_ready[c+1] = 1;
                exp_busy[c+1] = 1;
            end
        end else if (s && c > busy_end) begin
            m_recv = 1;
            m_idx = 0;
            exp_ready[c+1] = 1;
            exp_busy[c+1] = 1;
        end
    endtask

    task automatic step(input bit s, input bit a, input bit v,
                        output logic [W-1:0] obs, output logic [W-1:0] exp);
        bit m;
        i_start = s; i_abort = a; i_rx_valid = v;
        @(negedge clk);
        m = exp_en_a[cyc] || exp_en_t[cyc];
        obs = {o_rx_ready, o_en_b, o_en_a, o_sm_we, o_en_t, o_busy, o_done,
               m ? o_sm_addr : CW'(0)};
        exp = {exp_ready[cyc], exp_en_b[cyc], exp_en_a[cyc], exp_en_a[cyc],
               exp_en_t[cyc], exp_busy[cyc], exp_done[cyc],
               m ? CW'(exp_addr[cyc]) : CW'(0)};
        model(s, a, v);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [W-1:0] obs, exp;
        #1;
        obs = {o_rx_ready, o_en_b, o_en_a, o_sm_we, o_en_t, o_busy, o_done, o_sm_addr};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state got %b want %b", obs, {W{1'b0}});
        end
        #10 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL idle_valid cyc %0d got %b want %b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_streaming();
        logic [W-1:0] obs, exp;
        int done_at;
        done_at = -1;
        step(1, 0, 0, obs, exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL stream_start got %b want %b", obs, exp);
        end
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 1, obs, exp);
            if (obs[CW] === 1'b1 && done_at < 0) done_at = k;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stream cyc %0d got %b want %b", k, obs, exp);
            end
        end
        checks++;
        if (done_at !== 11) begin
            errors++;
            $display("FAIL stream_done_latency got %0d want 11", done_at);
        end
    endtask

    task automatic test_bubbles();
        logic [W-1:0] obs, exp;
        bit pat[6] = '{1, 0, 1, 1, 0, 1};
        bit ena[20];
        step(1, 0, 0, obs, exp);
        for (int k = 0; k < 20; k++) begin
            step(0, 0, (k < 6) ? pat[k] : 1'b0, obs, exp);
            ena[k] = obs[W-3];
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL bubbles cyc %0d got %b want %b", k, obs, exp);
            end
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (ena[k+2] !== pat[k]) begin
                errors++;
                $display("FAIL bubble_en_a slot %0d got %b want %b", k, ena[k+2], pat[k]);
            end
        end
    endtask

    task automatic test_abort_trace();
        logic [W-1:0] obs, exp;
        int guard;
        guard = 0;
        step(1, 0, 0, obs, exp);
        while (!(exp_en_t[cyc] && exp_addr[cyc] == 2) && guard < 30) begin
            step(0, 0, 1, obs, exp);
            guard++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort_pre cyc %0d got %b want %b", cyc, obs, exp);
            end
        end
        checks++;
        if (guard >= 30) begin
            errors++;
            $display("FAIL abort_reach_addr2 got timeout want trace addr 2");
        end
        step(0, 1, 0, obs, exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL abort_cycle got %b want %b", obs, exp);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort_after cyc %0d got %b want %b", k, obs, exp);
            end
        end
        step(1, 0, 0, obs, exp);
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort_refill cyc %0d got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] obs, exp;
        step(1, 0, 0, obs, exp);
        step(0, 0, 1, obs, exp);
        step(0, 0, 1, obs, exp);
        i_rx_valid = 1'b1;
        #1 rst = 1'b0;
        #1;
        obs = {o_rx_ready, o_en_b, o_en_a, o_sm_we, o_en_t, o_busy, o_done, o_sm_addr};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset got %b want %b", obs, {W{1'b0}});
        end
        #1 rst = 1'b1;
        clear_from(cyc);
        m_recv = 0;
        busy_end = -1;
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL post_reset_idle cyc %0d got %b want %b", k, obs, exp);
            end
        end
        step(1, 0, 1, obs, exp);
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL post_reset_frame cyc %0d got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_start_collisions();
        logic [W-1:0] obs, exp;
        step(1, 1, 0, obs, exp);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL start_abort cyc %0d got %b want %b", k, obs, exp);
            end
        end
        for (int k = 0; k < 40; k++) begin
            step(k < 25, 0, 1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL start_busy cyc %0d got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] obs, exp;
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(7) == 0, $urandom_range(59) == 0,
                 $urandom_range(1) == 1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cyc %0d got %b want %b", k, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_bubbles();
        test_abort_trace();
        test_async_reset();
        test_start_collisions();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/viterbi_ctrl.md
VITERBI_CTRL -- requirements
Module: viterbi_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64: received symbols per frame, range 2..(2^CNT_W).
REQ-002 SHALL have parameter CNT_W, default 7: width of the symbol and traceback counters.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  one-cycle frame start request.
REQ-006 SHALL have port i_abort  input  1  synchronous abort of the current frame.
REQ-007 SHALL have port i_rx_valid  input  1  soft symbol present on the branch-metric input.
REQ-008 SHALL have port o_rx_ready  output  1  controller accepts a symbol this cycle.
REQ-009 SHALL have port o_en_b  output  1  branch-metric enable.
REQ-010 SHALL have port o_en_a  output  1  add-compare-select enable.
REQ-011 SHALL have port o_sm_we  output  1  survivor-memory write enable.
REQ-012 SHALL have port o_sm_addr  output  CNT_W  survivor-memory write/read address.
REQ-013 SHALL have port o_en_t  output  1  traceback enable.
REQ-014 SHALL have port o_busy  output  1  frame in progress.
REQ-015 SHALL have port o_done  output  1  one-cycle frame-complete pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, DRAIN, TRACE, and SHALL register all outputs.
REQ-017 IDLE: on i_start=1, SHALL go to RECV next cycle and clear the symbol counter to 0.
REQ-018 RECV: o_rx_ready SHALL be 1; an accept is i_rx_valid&&o_rx_ready.
REQ-019 Each accept SHALL increment the symbol counter by 1.
REQ-020 Each accept at cycle t SHALL produce o_en_b=1 at t+1.
REQ-021 Each accept at cycle t SHALL produce o_en_a=1 and o_sm_we=1 at t+2, with o_sm_addr = that symbol's index (0-based).
REQ-022 Gaps in i_rx_valid SHALL produce matching gaps in o_en_b/o_en_a/o_sm_we: pipeline bubbles, no stall of stages in flight.
REQ-023 On the accept that brings the count to FRAME_LEN, SHALL go to DRAIN; o_rx_ready SHALL be 0 from the next cycle on.
REQ-024 DRAIN: SHALL last exactly 2 cycles so the final symbol's en_b/en_a complete, then SHALL go to TRACE.
REQ-025 TRACE: o_en_t SHALL be 1 for exactly FRAME_LEN consecutive cycles.
REQ-026 TRACE: o_sm_addr SHALL count down from FRAME_LEN-1 to 0, and o_sm_we SHALL be 0.
REQ-027 After the cycle with address 0, SHALL assert o_done for 1 cycle and return to IDLE.
REQ-028 o_busy SHALL be 1 in RECV, DRAIN and TRACE, and 0 in IDLE.
REQ-029 i_start outside IDLE SHALL be ignored.
REQ-030 i_rx_valid outside RECV SHALL be ignored and SHALL NOT change the counter.
REQ-031 i_abort=1 in any state SHALL, at the next edge, force IDLE and zero all outputs, including in-flight en_b/en_a/sm_we, with no o_done.
REQ-032 i_abort and i_start asserted together SHALL give IDLE: abort wins, start is dropped.
REQ-033 The counter SHALL never wrap: once it reaches FRAME_LEN, no accept is possible.

Reset
REQ-034 rst=0 SHALL immediately force IDLE and set all outputs and counters to 0, regardless of clk.
REQ-035 Reset mid-frame SHALL discard the frame; after release, the block SHALL wait in IDLE for i_start.

Verification (FRAME_LEN=4)
REQ-036 Streaming: start, then valid held 1 -> ready cycles 1-4; en_b cycles 2-5; en_a/sm_we cycles 3-6 with addr 0,1,2,3; DRAIN; en_t 4 cycles with addr 3,2,1,0; done pulse; busy falls with done.
REQ-037 Bubbles: valid pattern 1,0,1,1,0,1 -> en_a pattern identical, delayed 2 cycles; addresses 0..3 with no skips.
REQ-038 Abort during TRACE at addr 2 -> next cycle all outputs 0, IDLE, no done; new start runs a full clean frame.
REQ-039 Async reset pulse mid-RECV, between clock edges -> outputs 0 before the next edge; valid held after release -> ready stays 0 until start.
REQ-040 start while busy, and start together with abort -> both ignored; frame timing unchanged, or IDLE respectively.
